// File: rtl/gen_round_keys.sv
// PRESENT-80 key schedule: one 64-bit round key per clock, K1..K_lim; K_n is valid n-1 clocks after reset release.
// No backpressure; holds at K_lim. Optional done/round_idx outputs enabled by GEN_ROUND_KEYS_DONE_EN.
module gen_round_keys #(
  parameter int KEY_W      = 80,
  parameter int RK_W       = 64,
  parameter int MAX_ROUNDS = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [KEY_W-1:0]  key,
  input  logic [7:0]        rounds,
  output logic [RK_W-1:0]   round_out,
`ifdef GEN_ROUND_KEYS_DONE_EN
  output logic              done,
  output logic [4:0]        round_idx,
`endif
  output logic [KEY_W-1:0]  aux
);

  logic [KEY_W-1:0] kr_q, kr_d, rot;
  logic [7:0]       i_q, i_d, lim;
  logic             adv;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  // rounds=0 behaves like 1; anything above MAX_ROUNDS clamps
  always_comb begin
    if (rounds == 8'd0)
      lim = 8'd1;
    else if (rounds > 8'(MAX_ROUNDS))
      lim = 8'(MAX_ROUNDS);
    else
      lim = rounds;
  end

  assign adv = (i_q < lim);
  assign rot = {kr_q[18:0], kr_q[79:19]};

  always_comb begin
    kr_d = kr_q;
    i_d  = i_q;
    if (adv) begin
      kr_d          = rot;
      kr_d[79:76]   = sbox(rot[79:76]);
      kr_d[19:15]   = rot[19:15] ^ i_q[4:0];
      i_d           = i_q + 8'd1;
    end
  end

  // Reset loads the live key value, so holding reset keeps tracking key
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kr_q <= key;
      i_q  <= 8'd1;
    end else begin
      kr_q <= kr_d;
      i_q  <= i_d;
    end
  end

`ifdef GEN_ROUND_KEYS_DONE_EN
  logic done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      done_q <= 1'b0;
    else
      done_q <= done_q | (i_d >= lim);
  end

  assign done      = done_q;
  assign round_idx = i_q[4:0];
`endif

  assign aux       = kr_q;
  assign round_out = kr_q[79:16];

endmodule

// File: tb/tb_gen_round_keys.sv
// Bench for gen_round_keys: directed key-schedule vectors plus randomized runs against a behavioural model.
module tb_gen_round_keys;

  logic        clock;
  logic        reset_n;
  logic [79:0] key;
  logic [7:0]  rounds;
  logic [63:0] round_out;
  logic [79:0] aux;
`ifdef GEN_ROUND_KEYS_DONE_EN
  logic        done;
  logic [4:0]  round_idx;
`endif

  gen_round_keys dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key       (key),
    .rounds    (rounds),
    .round_out (round_out),
`ifdef GEN_ROUND_KEYS_DONE_EN
    .done      (done),
    .round_idx (round_idx),
`endif
    .aux       (aux)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [79:0] m_kr;
  int          m_i;
  bit          m_done;

  logic [3:0] sbox_tab [16];

  function automatic logic [79:0] sched(input logic [79:0] kr, input int r);
    logic [79:0] t;
    logic [4:0]  r5;
    t  = (kr << 61) | (kr >> 19);
    t[79:76] = sbox_tab[t[79:76]];
    r5 = r[4:0];
    t[19:15] = t[19:15] ^ r5;
    return t;
  endfunction

  function automatic int eff_lim(input int r);
    if (r == 0) return 1;
    if (r > 32) return 32;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".aux"}, aux, m_kr);
    chk({tag, ".rk"}, {16'h0, round_out}, {16'h0, m_kr[79:16]});
`ifdef GEN_ROUND_KEYS_DONE_EN
    chk({tag, ".done"}, {79'h0, done}, {79'h0, m_done});
    chk({tag, ".idx"}, {75'h0, round_idx}, 80'(m_i % 32));
`endif
  endtask

  // one rising edge, model advanced with the rounds value present at that edge
  task automatic tick();
    int lim;
    @(posedge clock);
    lim = eff_lim(int'(rounds));
    if (m_i < lim) begin
      m_kr = sched(m_kr, m_i);
      m_i++;
    end
    if (m_i >= lim) m_done = 1'b1;
    #2;
  endtask

  task automatic start(input logic [79:0] k, input logic [7:0] r);
    @(negedge clock);
    rounds  = r;
    key     = k;
    reset_n = 1'b0;
    m_kr = k; m_i = 1; m_done = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [79:0] ones;
    sbox_tab = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    ones    = '1;
    reset_n = 1'b1;
    key     = '0;
    rounds  = 8'd32;
    m_kr = '0; m_i = 1; m_done = 1'b0;

    // zero key, full 32 rounds
    start(80'h0, 8'd32);
    chk("k0.reset.aux", aux, 80'h0);
    chk("k0.reset.rk", {16'h0, round_out}, 80'h0);
    chk_model("k0.reset");
    tick();
    chk("k0.K2.rk", {16'h0, round_out}, {16'h0, 64'hC000000000000000});
    chk("k0.K2.aux", aux, 80'hC0000000000000008000);
    tick();
    chk("k0.K3.rk", {16'h0, round_out}, {16'h0, 64'h5000180000000001});
    for (int c = 3; c <= 31; c++) begin
      tick();
      chk_model($sformatf("k0.c%0d", c));
    end
    chk("k0.K32.rk", {16'h0, round_out}, {16'h0, 64'h6DAB31744F41D700});
`ifdef GEN_ROUND_KEYS_DONE_EN
    chk("k0.K32.done", {79'h0, done}, 80'h1);
`endif
    key = ones;  // no effect after reset
    for (int c = 0; c < 12; c++) tick();
    chk("k0.hold.rk", {16'h0, round_out}, {16'h0, 64'h6DAB31744F41D700});
    chk_model("k0.hold");

    // rounds=3 stops at K3
    start(80'h0, 8'd3);
    tick(); tick();
    chk("r3.K3.rk", {16'h0, round_out}, {16'h0, 64'h5000180000000001});
    for (int c = 0; c < 20; c++) tick();
    chk("r3.hold.rk", {16'h0, round_out}, {16'h0, 64'h5000180000000001});
    chk_model("r3.hold");

    // asynchronous reset between edges mid-run
    start(80'h0, 8'd32);
    for (int c = 0; c < 10; c++) tick();
    chk_model("ar.pre");
    #1;
    key     = ones;
    reset_n = 1'b0;
    m_kr = ones; m_i = 1; m_done = 1'b0;
    #1;
    chk("ar.aux", aux, ones);
    chk("ar.rk", {16'h0, round_out}, {16'h0, 64'hFFFFFFFFFFFFFFFF});
    chk_model("ar.held");
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_model($sformatf("ar.post%0d", c));
    end

    // rounds=0 holds K1
    start(80'h0, 8'd0);
    for (int c = 0; c < 15; c++) tick();
    chk("r0.hold.rk", {16'h0, round_out}, 80'h0);
    chk_model("r0.hold");

    // rounds=200 clamps at K32
    start(80'h0, 8'd200);
    for (int c = 0; c < 31; c++) tick();
    chk("r200.K32.rk", {16'h0, round_out}, {16'h0, 64'h6DAB31744F41D700});
    for (int c = 0; c < 10; c++) tick();
    chk("r200.hold.rk", {16'h0, round_out}, {16'h0, 64'h6DAB31744F41D700});

    // randomized keys/limits, with limit changes mid-run
    for (int t = 0; t < 12; t++) begin
      logic [79:0] rk;
      rk = {$urandom(), $urandom(), $urandom()};
      start(rk, 8'($urandom_range(0, 40)));
      chk_model($sformatf("rnd%0d.reset", t));
      for (int c = 0; c < 40; c++) begin
        if (c == 12 || c == 25) rounds = 8'($urandom_range(0, 255));
        if (c == 5) key = {$urandom(), $urandom(), $urandom()};
        tick();
        chk_model($sformatf("rnd%0d.c%0d", t, c));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
